// File: rtl/disp_scan.sv
// disp_scan: four-digit multiplexed 7-segment scan controller.
// A prescaler holds each digit for DIV clocks, and the digit index walks 0..3.
// New values are double-buffered and only reach the display at a frame boundary.
// Optional build macro: DISP_SCAN_LZ_BLANK_EN turns on leading-zero blanking of
// digits 3..1. Digit 0 is always lit.
module disp_scan #(
    parameter int DIV   = 50000,
    parameter int DIV_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dots,
    output logic [3:0]  x,
    output logic        dot,
    output logic [3:0]  an,
    output logic        frame_tick,
    output logic        upd_done
);

    localparam logic [DIV_W-1:0] CNT_MAX = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      active_q, active_d;
    logic [3:0]       active_dots_q, active_dots_d;
    logic [15:0]      pend_val_q, pend_val_d;
    logic [3:0]       pend_dots_q, pend_dots_d;
    logic             pend_flag_q, pend_flag_d;
    logic             upd_done_q, upd_done_d;

    logic             cnt_wrap;
    logic             boundary;

    assign cnt_wrap = (cnt_q == CNT_MAX);
    // The last cycle of digit 3 is the only point where the active buffer may change.
    assign boundary = cnt_wrap && (idx_q == 2'd3);

    // Next-state logic: prescaler, digit index and buffer transfer.
    always_comb begin
        cnt_d         = cnt_wrap ? '0 : cnt_q + DIV_W'(1);
        idx_d         = cnt_wrap ? idx_q + 2'd1 : idx_q;
        active_d      = active_q;
        active_dots_d = active_dots_q;
        pend_val_d    = pend_val_q;
        pend_dots_d   = pend_dots_q;
        pend_flag_d   = pend_flag_q;
        upd_done_d    = 1'b0;
        if (load && boundary) begin
            // A load that coincides with the boundary goes straight to the display.
            active_d      = value;
            active_dots_d = dots;
            pend_flag_d   = 1'b0;
            upd_done_d    = 1'b1;
        end else if (load) begin
            // A later load in the same frame simply overwrites the earlier one.
            pend_val_d    = value;
            pend_dots_d   = dots;
            pend_flag_d   = 1'b1;
        end else if (boundary && pend_flag_q) begin
            active_d      = pend_val_q;
            active_dots_d = pend_dots_q;
            pend_flag_d   = 1'b0;
            upd_done_d    = 1'b1;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            idx_q         <= 2'd0;
            active_q      <= 16'h0000;
            active_dots_q <= 4'h0;
            pend_val_q    <= 16'h0000;
            pend_dots_q   <= 4'h0;
            pend_flag_q   <= 1'b0;
            upd_done_q    <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            active_q      <= active_d;
            active_dots_q <= active_dots_d;
            pend_val_q    <= pend_val_d;
            pend_dots_q   <= pend_dots_d;
            pend_flag_q   <= pend_flag_d;
            upd_done_q    <= upd_done_d;
        end
    end

    // Outputs are decoded only from registers, so no input reaches an output combinationally.
    assign x          = active_q[{idx_q, 2'b00} +: 4];
    assign dot        = active_dots_q[idx_q];
    assign frame_tick = boundary;
    assign upd_done   = upd_done_q;

`ifdef DISP_SCAN_LZ_BLANK_EN
    logic [3:0] blank_mask;

    // Digit 0 is never blanked, so "0" is still visible for a zero value.
    assign blank_mask[0] = 1'b0;

    // Blank a digit whose nibble and all higher nibbles are zero and whose dot is off.
    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_blank
            assign blank_mask[gi] = (active_q[15:4*gi] == '0) && !active_dots_q[gi];
        end
    endgenerate

    assign an = ~(4'b0001 << idx_q) | blank_mask;
`else
    assign an = ~(4'b0001 << idx_q);
`endif

endmodule

// File: tb/tb_disp_scan.sv
// tb_disp_scan: randomized bench for disp_scan with DIV=4.
// The reference model tracks the elapsed cycles since reset release and the
// displayed and pending values. Digit and frame position are derived from the
// cycle count arithmetically.
module tb_disp_scan;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dots = 4'h0;
    logic [3:0]  x;
    logic        dot;
    logic [3:0]  an;
    logic        frame_tick;
    logic        upd_done;

    disp_scan #(.DIV(DIV), .DIV_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .dots       (dots),
        .x          (x),
        .dot        (dot),
        .an         (an),
        .frame_tick (frame_tick),
        .upd_done   (upd_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int          t = 0;
    logic [15:0] m_val = 16'h0000;
    logic [3:0]  m_dots = 4'h0;
    logic [15:0] p_val = 16'h0000;
    logic [3:0]  p_dots = 4'h0;
    bit          p_valid = 1'b0;
    bit          m_upd = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0d)", tag, got, exp, t);
        end
    endtask

    function automatic logic [3:0] exp_an();
        int d;
        logic [3:0] a;
        d = (t / DIV) % 4;
        a = ~(4'b0001 << d);
`ifdef DISP_SCAN_LZ_BLANK_EN
        for (int n = 1; n < 4; n++)
            if ((m_val >> (4 * n)) == 16'h0000 && !m_dots[n]) a[n] = 1'b1;
`endif
        return a;
    endfunction

    task automatic check_outputs();
        int d;
        logic [3:0] ex;
        d  = (t / DIV) % 4;
        ex = 4'((m_val >> (4 * d)) & 16'h000F);
        chk("an", an, exp_an());
        chk("x", x, ex);
        chk("dot", dot, m_dots[d]);
        chk("frame_tick", frame_tick, (t % FRAME) == FRAME - 1);
        chk("upd_done", upd_done, m_upd);
    endtask

    // One clock cycle: drive inputs, check current outputs, advance DUT and model.
    task automatic step(input bit ld, input logic [15:0] v, input logic [3:0] dt);
        bit bnd;
        load  = ld;
        value = v;
        dots  = dt;
        bnd   = (t % FRAME) == FRAME - 1;
        check_outputs();
        if (ld) $display("load value=%h dots=%b t=%0d%s", v, dt, t, bnd ? " boundary" : "");
        @(posedge clk);
        m_upd = 1'b0;
        if (ld && bnd) begin
            m_val = v; m_dots = dt; p_valid = 1'b0; m_upd = 1'b1;
        end else if (ld) begin
            p_val = v; p_dots = dt; p_valid = 1'b1;
        end else if (bnd && p_valid) begin
            m_val = p_val; m_dots = p_dots; p_valid = 1'b0; m_upd = 1'b1;
        end
        t++;
        #1;
        load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 4'h0);
    endtask

    // Advance until the DUT reports frame_tick, within one frame's budget.
    task automatic run_to_tick();
        for (int i = 0; i <= FRAME; i++) begin
            if (frame_tick === 1'b1) return;
            step(1'b0, 16'h0000, 4'h0);
        end
        chk("tick_timeout", 32'd0, 32'd1);
    endtask

    // Assert reset between clock edges, check outputs at once, release at a negedge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_an", an, 4'b1110);
        chk("rst_x", x, 4'h0);
        chk("rst_dot", dot, 1'b0);
        chk("rst_tick", frame_tick, 1'b0);
        chk("rst_upd", upd_done, 1'b0);
        $display("reset asserted mid-cycle at t=%0d", t);
        t = 0; m_val = '0; m_dots = '0; p_valid = 1'b0; m_upd = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Power-on reset
        #1;
        chk("por_an", an, 4'b1110);
        chk("por_x", x, 4'h0);
        chk("por_upd", upd_done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Scan sequence after release
        idle(2 * FRAME);

        // Mid-frame load, shown only after the boundary
        idle(5);
        step(1'b1, 16'h1234, 4'b0001);
        run_to_tick();
        step(1'b0, 16'h0000, 4'h0);
        chk("l1234_upd", upd_done, 1'b1);
        chk("l1234_x0", x, 4'h4);
        chk("l1234_dot0", dot, 1'b1);
        idle(FRAME);

        // Two loads merged into one transfer
        idle(2);
        step(1'b1, 16'h1111, 4'h0);
        idle(3);
        step(1'b1, 16'hABCD, 4'h0);
        run_to_tick();
        step(1'b0, 16'h0000, 4'h0);
        chk("merge_x0", x, 4'hD);
        idle(FRAME);

        // Load on the boundary cycle
        run_to_tick();
        step(1'b1, 16'hBEEF, 4'h0);
        chk("bnd_x0", x, 4'hF);
        chk("bnd_upd", upd_done, 1'b1);
        idle(FRAME);

        // Leading-zero patterns
        step(1'b1, 16'h0050, 4'h0);
        idle(2 * FRAME);
        step(1'b1, 16'h0000, 4'h0);
        idle(2 * FRAME);

        // Reset with a pending load: the pending value must never appear
        idle(6);
        step(1'b1, 16'h5A5A, 4'hF);
        do_reset();
        idle(2 * FRAME);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 900; i++) begin
            if (i % 300 == 299) do_reset();
            step($urandom_range(0, 6) == 0, 16'($urandom), 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/disp_scan.md
DISP_SCAN -- requirements
Module: disp_scan

Interface
REQ-001 SHALL have parameter DIV, default 50000, meaning clock cycles each digit is held; legal range 2 to 2^DIV_W-1.
REQ-002 SHALL have parameter DIV_W, default 16, meaning prescaler counter width.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port load, input, 1, one-cycle request to capture value and dots.
REQ-006 SHALL have port value, input, 16, four hex nibbles; [3:0] is digit 0 (rightmost).
REQ-007 SHALL have port dots, input, 4, decimal point per digit, active-high; bit n is digit n.
REQ-008 SHALL have port x, output, 4, nibble of the selected digit, fed to the segment decoder's x input.
REQ-009 SHALL have port dot, output, 1, dot of the selected digit, fed to the decoder's dot input.
REQ-010 SHALL have port an, output, 4, digit anode enables, active-low.
REQ-011 SHALL have port frame_tick, output, 1, high during the last cycle of digit 3.
REQ-012 SHALL have port upd_done, output, 1, one-cycle pulse when a new value becomes displayed.

Function
REQ-013 SHALL count prescaler cnt from 0 to DIV-1, then wrap to 0.
REQ-014 SHALL advance digit index idx 0->1->2->3->0 on each cnt wrap only.
REQ-015 SHALL drive an as active-low one-hot of idx (idx=0 -> 4'b1110), subject to REQ-024.
REQ-016 SHALL drive x = active[4*idx+3 : 4*idx] and dot = active_dots[idx].
REQ-017 SHALL drive x, dot, an, frame_tick only from registered state; no combinational path from any input to any output.
REQ-018 SHALL, on load, capture value/dots into pending registers and set the pending flag; a later load before transfer overwrites pending.
REQ-019 SHALL define the frame boundary as the cycle with cnt==DIV-1 and idx==3; frame_tick is high exactly then.
REQ-020 SHALL, at the boundary edge with pending set, copy pending to active, clear pending, pulse upd_done the next cycle.
REQ-021 SHALL, when load coincides with the boundary cycle, write the load inputs directly to active on that edge, leave pending clear, and pulse upd_done the next cycle.
REQ-022 SHALL leave active unchanged at any time other than the boundary edge; no mid-frame tearing.
REQ-023 SHALL produce exactly one upd_done per transfer, regardless of how many loads were merged.

Reset
REQ-025 SHALL, while rst_n is low, with no clock required, force cnt=0, idx=0, active=0, active_dots=0, pending=0, pending flag=0.
REQ-026 SHALL, while rst_n is low, force outputs an=4'b1110, x=0, dot=0, frame_tick=0, upd_done=0.
REQ-027 SHALL discard any pending load when reset is asserted mid-frame; the first digit after release is digit 0 for DIV cycles.

Configuration
REQ-024 SHALL, with macro DISP_SCAN_LZ_BLANK_EN defined, hold an[n] high (blanked) for digit n in 3..1 when its nibble and all more-significant nibbles are zero and dots[n] is clear.
REQ-028 SHALL, under DISP_SCAN_LZ_BLANK_EN, never blank digit 0, and leave x/dot/timing unchanged.
REQ-029 SHALL, without DISP_SCAN_LZ_BLANK_EN, enable every digit in its slot with no blanking logic present.

Verification (DIV=4)
REQ-030 SHALL check reset: rst_n low -> an=1110, x=0, upd_done=0; after release an steps 1110,1101,1011,0111, 4 cycles each, frame_tick once per 16 cycles.
REQ-031 SHALL check load value=16'h1234, dots=4'b0001 mid-frame -> display unchanged until boundary, then one upd_done; digit 0 x=4 dot=1; digit 3 x=1 dot=0.
REQ-032 SHALL check loads h1111 then hABCD in one frame -> only hABCD displayed, single upd_done.
REQ-033 SHALL check load hBEEF on the frame_tick cycle -> digit 0 next cycle shows x=F, upd_done pulses once.
REQ-034 SHALL check rst_n asserted between clock edges mid-frame with a load pending -> outputs reset immediately; pending value never displayed.
REQ-035 SHALL check macro on, value h0050 -> digits 3,2 blanked, 1,0 lit; h0000 -> only digit 0 lit; macro off -> all four lit.
